// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the score counter and the segment decoder stage.
package bcd_pkg;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [11:0] bcd3_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic logic bcd_is_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the +1/-1 chain: next digit plus carry/borrow toward the next digit up.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       up,
  input  logic       down,
  output bcd_digit_t next,
  output logic       carry,
  output logic       borrow
);

  // Opposing steps cancel, so only a lone up or a lone down moves the digit.
  always_comb begin
    next   = digit;
    carry  = 1'b0;
    borrow = 1'b0;
    if (up && !down) begin
      if (digit >= BCD_MAX) begin
        next  = BCD_ZERO;
        carry = 1'b1;
      end else begin
        next = digit + 4'd1;
      end
    end else if (down && !up) begin
      if (digit == BCD_ZERO) begin
        next   = BCD_MAX;
        borrow = 1'b1;
      end else begin
        next = digit - 4'd1;
      end
    end else begin
      next = digit;
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Three-digit packed-BCD up/down counter with synchronized edge-triggered steps,
// clear, checked parallel load and saturate-or-wrap at the range limits.
module bcd_score_counter
  import bcd_pkg::*;
#(
  parameter bit          SATURATE    = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  inc,
  input  logic  dec,
  input  logic  clear,
  input  logic  load,
  input  bcd3_t load_value,
  output bcd3_t valor,
  output logic  wrap,
  output logic  load_err
);

  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] dec_sync;
  logic                   inc_hist;
  logic                   dec_hist;
  logic                   inc_evt;
  logic                   dec_evt;

  logic [3:0] up_chain;
  logic [3:0] dn_chain;
  bcd3_t      step_value;
  logic       load_ok;

  bcd3_t valor_next;
  logic  wrap_next;
  logic  load_err_next;

  // Input synchronizers plus the history flop used for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_sync <= '0;
      dec_sync <= '0;
      inc_hist <= 1'b0;
      dec_hist <= 1'b0;
    end else begin
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], inc};
      dec_sync <= {dec_sync[SYNC_STAGES-2:0], dec};
      inc_hist <= inc_sync[SYNC_STAGES-1];
      dec_hist <= dec_sync[SYNC_STAGES-1];
    end
  end

  assign inc_evt = inc_sync[SYNC_STAGES-1] & ~inc_hist;
  assign dec_evt = dec_sync[SYNC_STAGES-1] & ~dec_hist;

  assign up_chain[0] = inc_evt;
  assign dn_chain[0] = dec_evt;

  // Units -> tens -> hundreds; the top carry/borrow flags a range overflow.
  for (genvar i = 0; i < 3; i++) begin : g_digit
    bcd_digit u_digit (
      .digit  (valor[4*i +: 4]),
      .up     (up_chain[i]),
      .down   (dn_chain[i]),
      .next   (step_value[4*i +: 4]),
      .carry  (up_chain[i+1]),
      .borrow (dn_chain[i+1])
    );
  end

  assign load_ok = bcd_is_valid(load_value[11:8]) &
                   bcd_is_valid(load_value[7:4])  &
                   bcd_is_valid(load_value[3:0]);

  // Priority: clear, load, then a lone step; simultaneous steps cancel.
  always_comb begin
    valor_next    = valor;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (clear) begin
      valor_next = 12'h000;
    end else if (load) begin
      if (load_ok) begin
        valor_next = load_value;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (inc_evt ^ dec_evt) begin
      if (up_chain[3] || dn_chain[3]) begin
        wrap_next  = 1'b1;
        valor_next = SATURATE ? valor : step_value;
      end else begin
        valor_next = step_value;
      end
    end else begin
      valor_next = valor;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valor    <= 12'h000;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      valor    <= valor_next;
      wrap     <= wrap_next;
      load_err <= load_err_next;
    end
  end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench for bcd_score_counter: one saturating and one wrapping instance share stimulus.
module tb_bcd_score_counter;

  logic        clk;
  logic        reset;
  logic        inc;
  logic        dec;
  logic        clear;
  logic        load;
  logic [11:0] load_value;

  logic [11:0] valor_s;
  logic        wrap_s;
  logic        err_s;
  logic [11:0] valor_w;
  logic        wrap_w;
  logic        err_w;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_score_counter #(.SATURATE(1'b1), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
    .load_value(load_value), .valor(valor_s), .wrap(wrap_s), .load_err(err_s)
  );

  bcd_score_counter #(.SATURATE(1'b0), .SYNC_STAGES(2)) dut_wrap (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
    .load_value(load_value), .valor(valor_w), .wrap(wrap_w), .load_err(err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  // One-cycle request; returns right after the edge that applies the step.
  task automatic pulse_step(input bit up);
    if (up) inc = 1'b1;
    else    dec = 1'b1;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    tick();
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; inc = 1'b0; dec = 1'b0; clear = 1'b0; load = 1'b0; load_value = 12'h000;
    idle(3);
    check("reset_valor_sat", valor_s, 12'h000);
    check("reset_valor_wrap", valor_w, 12'h000);
    check("reset_wrap", {11'd0, wrap_s}, 12'h000);
    check("reset_load_err", {11'd0, err_s}, 12'h000);
    reset = 1'b0;
    tick();

    // Held inc: one step, visible two edges after it is first sampled.
    inc = 1'b1;
    tick();
    check("inc_lat_k", valor_s, 12'h000);
    tick();
    check("inc_lat_k1", valor_s, 12'h000);
    tick();
    check("inc_lat_k2", valor_s, 12'h001);
    idle(7);
    check("inc_held_once", valor_s, 12'h001);
    inc = 1'b0;
    idle(3);

    // Carry and borrow chains.
    do_load(12'h099);
    check("load_099", valor_s, 12'h099);
    pulse_step(1'b1);
    check("carry_099_inc", valor_s, 12'h100);
    idle(2);
    do_load(12'h100);
    pulse_step(1'b0);
    check("borrow_100_dec", valor_s, 12'h099);
    idle(2);
    do_load(12'h910);
    pulse_step(1'b0);
    check("borrow_910_dec", valor_s, 12'h909);
    check("no_wrap_910", {11'd0, wrap_s}, 12'h000);
    idle(2);

    // Upper limit.
    do_load(12'h999);
    pulse_step(1'b1);
    check("sat_999_inc", valor_s, 12'h999);
    check("wrapdut_999_inc", valor_w, 12'h000);
    check("sat_wrap_hi", {11'd0, wrap_s}, 12'h001);
    check("wrapdut_wrap_hi", {11'd0, wrap_w}, 12'h001);
    tick();
    check("sat_wrap_hi_drop", {11'd0, wrap_s}, 12'h000);
    check("wrapdut_wrap_hi_drop", {11'd0, wrap_w}, 12'h000);
    idle(2);

    // Lower limit.
    do_load(12'h000);
    pulse_step(1'b0);
    check("sat_000_dec", valor_s, 12'h000);
    check("wrapdut_000_dec", valor_w, 12'h999);
    check("sat_wrap_lo", {11'd0, wrap_s}, 12'h001);
    check("wrapdut_wrap_lo", {11'd0, wrap_w}, 12'h001);
    tick();
    check("wrap_lo_drop", {11'd0, wrap_w}, 12'h000);
    idle(2);

    // Simultaneous inc and dec cancel.
    do_load(12'h500);
    inc = 1'b1;
    dec = 1'b1;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    tick();
    tick();
    check("cancel_valor", valor_s, 12'h500);
    check("cancel_wrap", {11'd0, wrap_s}, 12'h000);
    idle(3);
    check("cancel_valor_later", valor_s, 12'h500);

    // Clear beats a pending increment event.
    do_load(12'h250);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_vs_inc", valor_s, 12'h000);
    tick();
    check("clear_vs_inc_after", valor_s, 12'h000);
    idle(2);

    // Load beats a pending decrement event.
    do_load(12'h060);
    dec = 1'b1;
    tick();
    dec = 1'b0;
    tick();
    do_load(12'h123);
    check("load_vs_dec", valor_s, 12'h123);
    tick();
    check("load_vs_dec_after", valor_s, 12'h123);
    idle(2);

    // Invalid load rejected, valid load accepted.
    do_load(12'h042);
    do_load(12'h1A5);
    check("bad_load_keep", valor_s, 12'h042);
    check("bad_load_err", {11'd0, err_s}, 12'h001);
    tick();
    check("bad_load_err_drop", {11'd0, err_s}, 12'h000);
    do_load(12'h905);
    check("good_load_905", valor_s, 12'h905);
    check("good_load_no_err", {11'd0, err_s}, 12'h000);
    idle(2);

    // Asynchronous reset mid-count with inc held through release.
    do_load(12'h016);
    pulse_step(1'b1);
    check("count_017", valor_s, 12'h017);
    idle(2);
    inc = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_sat", valor_s, 12'h000);
    check("async_reset_wrap", valor_w, 12'h000);
    idle(2);
    reset = 1'b0;
    tick();
    tick();
    check("post_reset_k1", valor_s, 12'h000);
    tick();
    check("post_reset_step", valor_s, 12'h001);
    idle(5);
    check("post_reset_once_sat", valor_s, 12'h001);
    check("post_reset_once_wrap", valor_w, 12'h001);
    inc = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
